// File: rtl/universal_shift_reg.sv
// Universal shift register with a burst serialiser.
//
// In IDLE the register performs one of eight parallel/shift/rotate operations
// selected by `mode`. mode=110 loads `d` and starts a burst that shifts the
// loaded word out on `sout`, LSB first. One bit is sent per enabled cycle,
// for WIDTH enabled cycles in total. `done` then pulses for one cycle.
// mode=111 during a burst aborts it.
//
// Ports
//   clk   : clock; all state changes on the rising edge
//   rst   : synchronous active-high reset; has priority over everything
//   en    : clock enable; 0 freezes q, FSM and counter and forces done to 0
//   mode  : operation select (see case statement below)
//   d     : parallel data in
//   sin   : serial data in for the shift modes
//   q     : registered parallel data out
//   sout  : serial data out, combinational from q, mode and FSM state
//   busy  : 1 while a burst is in progress (decoded from the state flop)
//   done  : registered one-cycle pulse after the last burst bit
//
// Handshake: there is no valid/ready pair. A burst is requested by holding
// mode=110 with en=1 at a rising edge while busy=0. A new burst may be
// requested on the cycle where done=1.

module universal_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] q_n;
  logic             done_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= RESET_VAL;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      done  <= done_n;
    end
  end

  // Next-state logic. With en=0 everything holds and done_n stays 0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
    done_n  = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          case (mode)
            3'b000: q_n = q;
            3'b001: q_n = d;
            3'b010: q_n = {q[WIDTH-2:0], sin};
            3'b011: q_n = {sin, q[WIDTH-1:1]};
            3'b100: q_n = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b101: q_n = {q[0], q[WIDTH-1:1]};
            3'b110: begin
              q_n     = d;
              cnt_n   = '0;
              state_n = BURST;
            end
            3'b111: q_n = '0;
            default: q_n = q;
          endcase
        end
        BURST: begin
          if (mode == 3'b111) begin
            // Abort: clear everything, no done pulse.
            q_n     = '0;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            // q[0] always holds the bit being emitted, so shifting right
            // presents the next bit of the loaded word.
            q_n = {1'b0, q[WIDTH-1:1]};
            if (cnt == CNT_LAST) begin
              cnt_n   = '0;
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state == BURST);
    if (state == IDLE && (mode == 3'b010 || mode == 3'b100)) begin
      sout = q[WIDTH-1];
    end else begin
      sout = q[0];
    end
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits), value loaded into q on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  clock enable; when 0, all state (q, FSM, counter) holds and done is 0.
REQ-006 mode  input  3  operation select, sampled on rising edges with en=1.
REQ-007 d  input  WIDTH  parallel data in.
REQ-008 sin  input  1  serial data in.
REQ-009 q  output  WIDTH  registered parallel data out.
REQ-010 sout  output  1  serial data out, combinational from q and mode.
REQ-011 busy  output  1  registered; 1 while a burst serialisation is in progress.
REQ-012 done  output  1  registered; one-cycle pulse marking burst completion.

Function
REQ-013 FSM states SHALL be IDLE and BURST, plus a bit counter cnt of ceil(log2(WIDTH)) bits.
REQ-014 In IDLE with en=1, mode SHALL act on q: 000 hold; 001 q<=d; 010 q<={q[WIDTH-2:0],sin}; 011 q<={sin,q[WIDTH-1:1]}; 100 rotate left by 1; 101 rotate right by 1; 111 q<=0.
REQ-015 In IDLE with en=1 and mode=110, q SHALL load d, cnt SHALL load 0, and the state SHALL become BURST (busy=1 from the next cycle).
REQ-016 In BURST with en=1 and mode!=111, q SHALL shift right inserting 0 and mode is otherwise ignored; cnt SHALL increment while cnt<WIDTH-1.
REQ-017 In BURST with en=1 and cnt==WIDTH-1, the final shift SHALL occur, state SHALL return to IDLE, busy SHALL drop and done SHALL be 1 for exactly the next cycle.
REQ-018 While busy=1, sout SHALL equal d_loaded[cnt], i.e. bits are emitted LSB first, one per enabled cycle, WIDTH enabled cycles total.
REQ-019 In BURST with en=1 and mode=111, q SHALL clear to 0, state SHALL return to IDLE, cnt SHALL clear, done SHALL stay 0 (abort).
REQ-020 sout SHALL be q[WIDTH-1] when state=IDLE and mode is 010 or 100, otherwise q[0].
REQ-021 en=0 during BURST SHALL stall the burst without losing bits; done SHALL never assert on a cycle where en was 0 at the preceding edge.
REQ-022 done SHALL be 0 in every cycle other than the one following a completed burst; back-to-back bursts (mode=110 on the cycle done=1) SHALL be accepted.
REQ-023 Rotate modes SHALL ignore sin; shift modes SHALL never alter bits other than by the stated shift.

Reset
REQ-024 With rst=1 at a rising edge: q<=RESET_VAL, state<=IDLE, cnt<=0, busy<=0, done<=0, regardless of en or mode.
REQ-025 rst SHALL have priority over en and every mode, including mid-burst; an interrupted burst SHALL NOT produce done.
REQ-026 Before the first reset edge, output values are undefined and not checked.

Verification (WIDTH=8, RESET_VAL=8'h00 unless stated)
REQ-027 Reset, then en=1 mode=001 d=8'hA5, then mode=000 for 3 cycles -> q=8'hA5 held, busy=0, done=0.
REQ-028 q=8'h81, mode=010 sin=0 one cycle -> q=8'h02; then mode=100 from q=8'h81 -> q=8'h03; mode=101 from q=8'h01 -> q=8'h80.
REQ-029 en=1 mode=110 d=8'hB4 -> busy=1 for 8 cycles, sout sequence 0,0,1,0,1,1,0,1, done=1 the cycle after, q=8'h00.
REQ-030 Same burst with en=0 for 2 cycles after the 3rd bit -> sout holds, remaining bits emitted unchanged, done after 10 cycles of busy.
REQ-031 Burst of 8'hFF aborted by mode=111 after 4 bits -> q=0, busy=0 next cycle, done never asserts.
REQ-032 RESET_VAL=8'h3C, rst asserted mid-burst with en=0 -> next cycle q=8'h3C, busy=0, done=0.
